// File: rtl/seg_frame_decoder.sv
// rtl/seg_frame_decoder.sv - decodes a stream of 7-segment digit patterns into a BCD + binary frame result
// Digits arrive most-significant first; the completed frame is held until the consumer accepts it.
module seg_frame_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic                    seg_valid,
    input  logic                    seg_first,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [BIN_W-1:0]        bin_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    frame_err,
    output logic                    overrun
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BIN_W-1:0]   acc_q, acc_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic               err_q, err_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;

    // Returns {bad, nibble}; blank decodes to 0 without error.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1111011: r = 5'h09;
            7'b0000000: r = 5'h00;
            default:    r = 5'h1F;
        endcase
        return r;
    endfunction

    logic [4:0]       dec;
    logic [BCD_W-1:0] nib_ext;
    logic [IDX_W-1:0] idx_inc;
    logic [BIN_W-1:0] acc_new;
    logic [BCD_W-1:0] work_new;
    logic             err_new;
    logic             last_dig;
    logic             take;

    always_comb begin
        dec          = decode_seg(seg_in);
        nib_ext      = '0;
        nib_ext[3:0] = dec[3:0];
        // seg_first always starts from a clean frame, whatever was partially collected.
        idx_inc  = (seg_first ? '0 : idx_q) + IDX_W'(1);
        acc_new  = (seg_first ? '0 : acc_q) * BIN_W'(10) + BIN_W'(dec[3:0]);
        work_new = ((seg_first ? '0 : work_q) << 4) | nib_ext;
        err_new  = (seg_first ? 1'b0 : err_q) | dec[4];
        last_dig = (idx_inc == IDX_W'(NUM_DIGITS));

        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        work_d  = work_q;
        err_d   = err_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
        take    = 1'b0;

        case (state_q)
            IDLE:    take = seg_valid & seg_first;
            COLLECT: take = seg_valid;
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    take    = seg_valid & seg_first;
                end else begin
                    ovr_d = seg_valid;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            idx_d  = idx_inc;
            acc_d  = acc_new;
            work_d = work_new;
            err_d  = err_new;
            if (last_dig) begin
                state_d = HOLD;
                bcd_d   = work_new;
                bin_d   = err_new ? '0 : acc_new;
                ferr_d  = err_new;
            end else begin
                state_d = COLLECT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            work_q  <= '0;
            err_q   <= 1'b0;
            bcd_q   <= '0;
            bin_q   <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            work_q  <= work_d;
            err_q   <= err_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign bin_out   = bin_q;
    assign out_valid = (state_q == HOLD);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// tb/tb_seg_frame_decoder.sv - directed and randomized checks of seg_frame_decoder against a digit-level model
module tb_seg_frame_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg_in;
    logic        seg_valid;
    logic        seg_first;
    logic [15:0] bcd_out;
    logic [13:0] bin_out;
    logic        out_valid;
    logic        out_ready;
    logic        frame_err;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_bcd;
    logic [31:0] exp_bin;
    logic        exp_err;

    seg_frame_decoder #(.NUM_DIGITS(4), .BIN_W(14)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .seg_first (seg_first),
        .bcd_out   (bcd_out),
        .bin_out   (bin_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [6:0] s, input logic v, input logic f, input logic r);
        seg_in    = s;
        seg_valid = v;
        seg_first = f;
        out_ready = r;
        step();
    endtask

    // Digit codes: 0..9 real digits, 10 blank, 11 and 12 undecodable patterns.
    function automatic logic [6:0] pat(input int code);
        logic [6:0] tbl [0:12];
        tbl[0]  = 7'b1111110; tbl[1]  = 7'b0110000; tbl[2]  = 7'b1101101;
        tbl[3]  = 7'b1111001; tbl[4]  = 7'b0110011; tbl[5]  = 7'b1011011;
        tbl[6]  = 7'b1011111; tbl[7]  = 7'b1110000; tbl[8]  = 7'b1111111;
        tbl[9]  = 7'b1111011; tbl[10] = 7'b0000000; tbl[11] = 7'b1010101;
        tbl[12] = 7'b0000001;
        return tbl[code];
    endfunction

    function automatic int nib_of(input int code);
        if (code < 10) return code;
        if (code == 10) return 0;
        return 15;
    endfunction

    task automatic send_frame(input int d[4], input int max_gap);
        int early = 0;
        int val = 0;
        int bcdv = 0;
        logic bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                put(7'd0, 1'b0, 1'b0, 1'b0);
                if (out_valid) early++;
            end
            put(pat(d[i]), 1'b1, (i == 0), 1'b0);
            if (i < 3 && out_valid) early++;
            bcdv = bcdv * 16 + nib_of(d[i]);
            val  = val * 10 + ((d[i] < 10) ? d[i] : 0);
            if (d[i] > 10) bad = 1'b1;
        end
        exp_bcd = bcdv[15:0];
        exp_bin = bad ? 32'd0 : val;
        exp_err = bad;
        chk("early_valid", early, 0);
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("bcd_out", {16'd0, bcd_out}, {16'd0, exp_bcd});
        chk("bin_out", {18'd0, bin_out}, exp_bin);
        chk("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
    endtask

    task automatic accept();
        put(7'd0, 1'b0, 1'b0, 1'b1);
        chk("valid_after_accept", {31'd0, out_valid}, 32'd0);
        chk("bcd_kept", {16'd0, bcd_out}, {16'd0, exp_bcd});
        chk("bin_kept", {18'd0, bin_out}, exp_bin);
    endtask

    initial begin
        int d[4];
        int ovr_cnt;
        logic steady;

        reset = 1'b1; seg_in = 7'd0; seg_valid = 1'b0; seg_first = 1'b0; out_ready = 1'b0;
        step();
        step();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_bcd", {16'd0, bcd_out}, 32'd0);
        chk("rst_bin", {18'd0, bin_out}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        reset = 1'b0;

        put(pat(3), 1'b1, 1'b0, 1'b0);
        chk("idle_ignore_nonfirst", {31'd0, out_valid}, 32'd0);

        d = '{1, 2, 3, 4}; send_frame(d, 0);
        chk("bcd_1234", {16'd0, bcd_out}, 32'h1234);
        accept();
        d = '{9, 9, 9, 9}; send_frame(d, 1); accept();
        d = '{10, 10, 1, 0}; send_frame(d, 2);
        chk("bcd_0010", {16'd0, bcd_out}, 32'h0010);
        accept();
        d = '{1, 2, 11, 4}; send_frame(d, 0);
        chk("bcd_12F4", {16'd0, bcd_out}, 32'h12F4);
        accept();

        d = '{1, 2, 3, 4}; send_frame(d, 0);
        ovr_cnt = 0;
        steady  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            put(pat(7), (i % 2 == 0), (i == 2), 1'b0);
            if (overrun) ovr_cnt++;
            if (!out_valid || bin_out !== 14'd1234 || bcd_out !== 16'h1234) steady = 1'b0;
        end
        chk("overrun_pulses", ovr_cnt, 3);
        chk("held_steady", {31'd0, steady}, 32'd1);
        put(pat(5), 1'b1, 1'b1, 1'b1);
        chk("accept_with_first_valid", {31'd0, out_valid}, 32'd0);
        chk("accept_with_first_ovr", {31'd0, overrun}, 32'd0);
        put(pat(8), 1'b1, 1'b0, 1'b0);
        put(pat(7), 1'b1, 1'b0, 1'b0);
        put(pat(6), 1'b1, 1'b0, 1'b0);
        chk("restart_valid", {31'd0, out_valid}, 32'd1);
        chk("restart_bin", {18'd0, bin_out}, 32'd5876);
        exp_bcd = 16'h5876; exp_bin = 32'd5876;

        put(pat(3), 1'b1, 1'b0, 1'b1);
        chk("accept_nonfirst_valid", {31'd0, out_valid}, 32'd0);
        chk("accept_nonfirst_ovr", {31'd0, overrun}, 32'd0);
        put(pat(3), 1'b1, 1'b0, 1'b0);
        chk("nonfirst_ignored", {31'd0, out_valid}, 32'd0);

        put(pat(1), 1'b1, 1'b1, 1'b0);
        put(pat(2), 1'b1, 1'b0, 1'b0);
        d = '{5, 6, 7, 8}; send_frame(d, 0); accept();

        put(pat(9), 1'b1, 1'b1, 1'b0);
        put(pat(9), 1'b1, 1'b0, 1'b0);
        put(pat(9), 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        put(pat(9), 1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        chk("midreset_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_bcd", {16'd0, bcd_out}, 32'd0);
        chk("midreset_bin", {18'd0, bin_out}, 32'd0);
        d = '{4, 3, 2, 1}; send_frame(d, 0); accept();

        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < 4; i++) d[i] = $urandom_range(0, 12);
            send_frame(d, 2);
            repeat ($urandom_range(0, 3)) put(7'd0, 1'b0, 1'b0, 1'b0);
            chk("rand_hold_valid", {31'd0, out_valid}, 32'd1);
            accept();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
